// File: rtl/bebida_pkg.sv
// Shared types and constants for the beverage dispenser controller.
// Holds no logic: state encoding, stage codes and order-size limits only.
package bebida_pkg;

    localparam int MAX_UNITS = 3;
    localparam int UNIT_W    = $clog2(MAX_UNITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHOC  = 3'd1,
        ST_LECHE = 3'd2,
        ST_AZUC  = 3'd3,
        ST_SERVE = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [1:0] STG_NONE  = 2'd0;
    localparam logic [1:0] STG_CHOC  = 2'd1;
    localparam logic [1:0] STG_LECHE = 2'd2;
    localparam logic [1:0] STG_AZUC  = 2'd3;

endpackage

// File: rtl/bebida_ctrl_if.sv
// Panel and dispenser-stage signals of the drink controller, bundled as one port.
// master = controller side, slave = panel/dispensers side.
interface bebida_ctrl_if
    import bebida_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic              start;
    logic [UNIT_W-1:0] bebida;
    logic [UNIT_W-1:0] azucar;
    logic              done_chocolate;
    logic              done_leche;
    logic              done_azucar;
    logic              clear_err;
    logic              enable_chocolate;
    logic              enable_leche;
    logic              enable_azucar;
    logic [UNIT_W-1:0] cantidad;
    logic [UNIT_W-1:0] dosis_azucar;
    logic              busy;
    logic              led_listo;
    logic              error;
    logic              rejected;
    logic [CNT_W-1:0]  served_count;
    logic [1:0]        fail_stage;

    modport master (
        input  start, bebida, azucar, done_chocolate, done_leche, done_azucar, clear_err,
        output enable_chocolate, enable_leche, enable_azucar, cantidad, dosis_azucar,
               busy, led_listo, error, rejected, served_count, fail_stage
    );

    modport slave (
        output start, bebida, azucar, done_chocolate, done_leche, done_azucar, clear_err,
        input  enable_chocolate, enable_leche, enable_azucar, cantidad, dosis_azucar,
               busy, led_listo, error, rejected, served_count, fail_stage
    );

endinterface

// File: rtl/bebida_ctrl_stage_timer.sv
// Saturating up-counter; clr restarts at 0 and loads the terminal value, tc flags count==terminal.
// Latency: tc is registered-state derived, valid the cycle after clr; no backpressure.
module stage_timer #(
    parameter int MAX_COUNT = 16,
    parameter int W         = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] ld_val,
    output logic         tc
);

    logic [W-1:0] count;
    logic [W-1:0] last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            last  <= W'(MAX_COUNT - 1);
        end else if (clr) begin
            count <= '0;
            last  <= ld_val;
        end else if (en && (count != last)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/bebida_ctrl.sv
// Drink-order sequencer: chocolate -> milk -> optional sugar, with per-stage timeout and serve hold.
// Latency: every output registered, updating on the edge that samples its cause; dispensers pace it via done levels.
module bebida_ctrl
    import bebida_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DONE_CYCLES    = 4,
    parameter int CNT_W          = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    bebida_ctrl_if.master bus
);

    localparam int TMAX = (TIMEOUT_CYCLES > DONE_CYCLES) ? TIMEOUT_CYCLES : DONE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] STAGE_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] SERVE_LAST = TW'(DONE_CYCLES - 1);

    state_t            state, state_nxt;
    logic [UNIT_W-1:0] cantidad, cantidad_nxt;
    logic [UNIT_W-1:0] dosis, dosis_nxt;
    logic [1:0]        fail_stage, fail_nxt;
    logic [CNT_W-1:0]  served_count, served_nxt;
    logic              rejected, rejected_nxt;
    logic              en_choc, en_leche, en_azuc;
    logic              busy, led_listo, error;
    logic              tmr_clr, tmr_en, tmr_tc;
    logic [TW-1:0]     tmr_ld;

    always_comb begin
        state_nxt    = state;
        cantidad_nxt = cantidad;
        dosis_nxt    = dosis;
        fail_nxt     = fail_stage;
        served_nxt   = served_count;
        rejected_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.bebida != '0) begin
                        state_nxt    = ST_CHOC;
                        cantidad_nxt = bus.bebida;
                        dosis_nxt    = bus.azucar;
                    end else begin
                        rejected_nxt = 1'b1;
                    end
                end
            end
            // done is checked before the timeout so a done on the last cycle still advances
            ST_CHOC: begin
                if (bus.done_chocolate) begin
                    state_nxt = ST_LECHE;
                end else if (tmr_tc) begin
                    state_nxt = ST_ERROR;
                    fail_nxt  = STG_CHOC;
                end
            end
            ST_LECHE: begin
                if (bus.done_leche) begin
                    state_nxt = (dosis != '0) ? ST_AZUC : ST_SERVE;
                end else if (tmr_tc) begin
                    state_nxt = ST_ERROR;
                    fail_nxt  = STG_LECHE;
                end
            end
            ST_AZUC: begin
                if (bus.done_azucar) begin
                    state_nxt = ST_SERVE;
                end else if (tmr_tc) begin
                    state_nxt = ST_ERROR;
                    fail_nxt  = STG_AZUC;
                end
            end
            ST_SERVE: begin
                if (tmr_tc) state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                if (bus.clear_err) begin
                    state_nxt = ST_IDLE;
                    fail_nxt  = STG_NONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if ((state_nxt == ST_SERVE) && (state != ST_SERVE)) served_nxt = served_count + 1'b1;

        // one shared timer: restarted on every state change, terminal value picked for the new state
        tmr_clr = (state_nxt != state);
        tmr_en  = state inside {ST_CHOC, ST_LECHE, ST_AZUC, ST_SERVE};
        tmr_ld  = (state_nxt == ST_SERVE) ? SERVE_LAST : STAGE_LAST;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cantidad     <= '0;
            dosis        <= '0;
            fail_stage   <= STG_NONE;
            served_count <= '0;
            rejected     <= 1'b0;
            en_choc      <= 1'b0;
            en_leche     <= 1'b0;
            en_azuc      <= 1'b0;
            busy         <= 1'b0;
            led_listo    <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nxt;
            cantidad     <= cantidad_nxt;
            dosis        <= dosis_nxt;
            fail_stage   <= fail_nxt;
            served_count <= served_nxt;
            rejected     <= rejected_nxt;
            en_choc      <= (state_nxt == ST_CHOC);
            en_leche     <= (state_nxt == ST_LECHE);
            en_azuc      <= (state_nxt == ST_AZUC);
            busy         <= (state_nxt != ST_IDLE);
            led_listo    <= (state_nxt == ST_SERVE);
            error        <= (state_nxt == ST_ERROR);
        end
    end

    stage_timer #(
        .MAX_COUNT (TMAX),
        .W         (TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .ld_val (tmr_ld),
        .tc     (tmr_tc)
    );

    assign bus.enable_chocolate = en_choc;
    assign bus.enable_leche     = en_leche;
    assign bus.enable_azucar    = en_azuc;
    assign bus.cantidad         = cantidad;
    assign bus.dosis_azucar     = dosis;
    assign bus.busy             = busy;
    assign bus.led_listo        = led_listo;
    assign bus.error            = error;
    assign bus.rejected         = rejected;
    assign bus.served_count     = served_count;
    assign bus.fail_stage       = fail_stage;

    a_one_enable: assert property (@(posedge clk) $onehot0({en_choc, en_leche, en_azuc}));

endmodule

// File: tb/tb_bebida_ctrl.sv
// Directed bench for bebida_ctrl: order table plus hand sequences for start-in-stage, reset mid-order and counter wrap.
module tb_bebida_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bebida_ctrl_if #(.CNT_W(8)) bus ();

    bebida_ctrl #(
        .TIMEOUT_CYCLES (16),
        .DONE_CYCLES    (4),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] bebida;
        logic [1:0] azucar;
        int dc, dl, da;
        int e_choc, e_leche, e_azuc, e_led, e_rej, e_err, e_fail, e_inc, e_cant, e_dosis;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;

    // dispenser model: done rises once its enable has been high for dly cycles (0 = already high)
    int dly_c = 255, dly_l = 255, dly_a = 255;
    int cnt_c = 0, cnt_l = 0, cnt_a = 0;
    int m_choc = 0, m_leche = 0, m_azuc = 0, m_led = 0, m_rej = 0, m_overlap = 0;

    always @(negedge clk) begin
        cnt_c = bus.enable_chocolate ? cnt_c + 1 : 0;
        cnt_l = bus.enable_leche     ? cnt_l + 1 : 0;
        cnt_a = bus.enable_azucar    ? cnt_a + 1 : 0;
        bus.done_chocolate = (cnt_c >= dly_c);
        bus.done_leche     = (cnt_l >= dly_l);
        bus.done_azucar    = (cnt_a >= dly_a);
        m_choc  += int'(bus.enable_chocolate);
        m_leche += int'(bus.enable_leche);
        m_azuc  += int'(bus.enable_azucar);
        m_led   += int'(bus.led_listo);
        m_rej   += int'(bus.rejected);
        if (int'(bus.enable_chocolate) + int'(bus.enable_leche) + int'(bus.enable_azucar) > 1)
            m_overlap++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_monitors();
        m_choc = 0; m_leche = 0; m_azuc = 0; m_led = 0; m_rej = 0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (!bus.busy || bus.error) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_order(input vec_t v, input int idx);
        bit ok;
        dly_c = v.dc; dly_l = v.dl; dly_a = v.da;
        @(negedge clk);
        clear_monitors();
        bus.start  = 1'b1;
        bus.bebida = v.bebida;
        bus.azucar = v.azucar;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(300, ok);
        chk($sformatf("v%0d_finish", idx), int'(ok), 1);
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d_choc_cyc", idx),  m_choc,  v.e_choc);
        chk($sformatf("v%0d_leche_cyc", idx), m_leche, v.e_leche);
        chk($sformatf("v%0d_azuc_cyc", idx),  m_azuc,  v.e_azuc);
        chk($sformatf("v%0d_led_cyc", idx),   m_led,   v.e_led);
        chk($sformatf("v%0d_rej_cyc", idx),   m_rej,   v.e_rej);
        chk($sformatf("v%0d_error", idx),     int'(bus.error),      v.e_err);
        chk($sformatf("v%0d_busy", idx),      int'(bus.busy),       v.e_err);
        chk($sformatf("v%0d_fail_stage", idx), int'(bus.fail_stage), v.e_fail);
        chk($sformatf("v%0d_cantidad", idx),  int'(bus.cantidad),     v.e_cant);
        chk($sformatf("v%0d_dosis", idx),     int'(bus.dosis_azucar), v.e_dosis);
        if (v.e_err != 0) begin
            bus.clear_err = 1'b1;
            @(negedge clk);
            bus.clear_err = 1'b0;
            chk($sformatf("v%0d_clr_error", idx), int'(bus.error),      0);
            chk($sformatf("v%0d_clr_fail", idx),  int'(bus.fail_stage), 0);
            chk($sformatf("v%0d_clr_busy", idx),  int'(bus.busy),       0);
        end
        exp_count = (exp_count + v.e_inc) % 256;
        chk($sformatf("v%0d_served", idx), int'(bus.served_count), exp_count);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_en_choc"},  int'(bus.enable_chocolate), 0);
        chk({tag, "_en_leche"}, int'(bus.enable_leche),     0);
        chk({tag, "_en_azuc"},  int'(bus.enable_azucar),    0);
        chk({tag, "_cantidad"}, int'(bus.cantidad),         0);
        chk({tag, "_dosis"},    int'(bus.dosis_azucar),     0);
        chk({tag, "_busy"},     int'(bus.busy),             0);
        chk({tag, "_led"},      int'(bus.led_listo),        0);
        chk({tag, "_error"},    int'(bus.error),            0);
        chk({tag, "_rejected"}, int'(bus.rejected),         0);
        chk({tag, "_served"},   int'(bus.served_count),     0);
        chk({tag, "_fail"},     int'(bus.fail_stage),       0);
    endtask

    vec_t vt[8];

    initial begin
        bit ok;
        bit all_ok;

        //        beb   az    dc   dl   da  choc leche azuc led rej err fail inc cant dosis
        vt[0] = '{2'd2, 2'd1,   3,   3,   3,   3,   3,   3,  4,  0,  0,  0,  1,  2,  1};
        vt[1] = '{2'd3, 2'd0,   2,   2,   2,   2,   2,   0,  4,  0,  0,  0,  1,  3,  0};
        vt[2] = '{2'd0, 2'd2,   1,   1,   1,   0,   0,   0,  0,  1,  0,  0,  0,  3,  0};
        vt[3] = '{2'd1, 2'd2,   1, 255,   1,   1,  16,   0,  0,  0,  1,  2,  0,  1,  2};
        vt[4] = '{2'd1, 2'd3,  16,  16,  16,  16,  16,  16,  4,  0,  0,  0,  1,  1,  3};
        vt[5] = '{2'd2, 2'd1,   0,   1,   1,   1,   1,   1,  4,  0,  0,  0,  1,  2,  1};
        vt[6] = '{2'd2, 2'd0, 255,   1,   1,  16,   0,   0,  0,  0,  1,  1,  0,  2,  0};
        vt[7] = '{2'd3, 2'd1,   1,   1, 255,   1,   1,  16,  0,  0,  1,  3,  0,  3,  1};

        bus.start = 1'b0; bus.bebida = 2'd0; bus.azucar = 2'd0; bus.clear_err = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("rst");

        for (int i = 0; i < 8; i++) run_order(vt[i], i);

        // start pulse while milk stage runs must be ignored
        dly_c = 0; dly_l = 5; dly_a = 1;
        @(negedge clk);
        clear_monitors();
        bus.start = 1'b1; bus.bebida = 2'd2; bus.azucar = 2'd0;
        @(negedge clk);
        bus.start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.enable_leche) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("midstart_reach_leche", int'(ok), 1);
        @(negedge clk);
        bus.start = 1'b1; bus.bebida = 2'd1; bus.azucar = 2'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(100, ok);
        chk("midstart_finish", int'(ok), 1);
        repeat (2) @(negedge clk);
        exp_count = (exp_count + 1) % 256;
        chk("midstart_choc_cyc",  m_choc,  1);
        chk("midstart_leche_cyc", m_leche, 5);
        chk("midstart_azuc_cyc",  m_azuc,  0);
        chk("midstart_cantidad",  int'(bus.cantidad),     2);
        chk("midstart_dosis",     int'(bus.dosis_azucar), 0);
        chk("midstart_served",    int'(bus.served_count), exp_count);
        repeat (6) @(negedge clk);
        chk("midstart_no_second", int'(bus.busy), 0);
        chk("midstart_served2",   int'(bus.served_count), exp_count);

        // reset while the sugar stage is active
        dly_c = 1; dly_l = 1; dly_a = 255;
        @(negedge clk);
        bus.start = 1'b1; bus.bebida = 2'd1; bus.azucar = 2'd1;
        @(negedge clk);
        bus.start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.enable_azucar) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("rstmid_reach_azuc", int'(ok), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("rstmid");
        repeat (3) @(negedge clk);
        chk("rstmid_stays_idle", int'(bus.busy), 0);
        exp_count = 0;

        // 256 quick orders: the counter must wrap back to zero
        dly_c = 1; dly_l = 1; dly_a = 1;
        all_ok = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            @(negedge clk);
            bus.start = 1'b1; bus.bebida = 2'd1; bus.azucar = 2'd0;
            @(negedge clk);
            bus.start = 1'b0;
            wait_idle(50, ok);
            if (!ok) all_ok = 1'b0;
            if (n == 255) chk("wrap_255", int'(bus.served_count), 255);
        end
        chk("wrap_orders_finish", int'(all_ok), 1);
        chk("wrap_0", int'(bus.served_count), 0);

        chk("enable_overlap", m_overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
